mult8x8_seq: RTL

Sequential 8x8 unsigned multiplier that time-shares a single `mult4x4` instance (4x4 → 8-bit combinational product) over four cycles. It owns the operand registers, the nibble-select sequencing, the shift-and-add accumulator and the start/done handshake. It sits directly above `mult4x4` and is the block the rest of the design calls for 8-bit products.

---
 rtl/mult8x8_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mult8x8_seq.sv
// rtl/mult8x8_seq.sv - sequential 8x8 unsigned multiplier built on one shared 4x4 multiplier
//
// mult4x4: combinational 4x4 -> 8-bit unsigned product.
//   dataa   in  4   operand A
//   datab   in  4   operand B
//   product out 8   dataa * datab
//
// mult8x8_seq: 8x8 -> 16-bit unsigned product over four cycles using one mult4x4.
//   clk      in  1   clock, rising edge
//   reset_n  in  1   synchronous active-low reset
//   start    in  1   request pulse, accepted only in IDLE
//   dataa    in  8   multiplicand, sampled on the accepting edge
//   datab    in  8   multiplier, sampled on the accepting edge
//   product  out 16  registered result, held until the next result loads
//   done     out 1   one-cycle pulse when product has just loaded
//   busy     out 1   high from the cycle after acceptance through the DONE cycle

module mult4x4 (
  input  logic [3:0] dataa,
  input  logic [3:0] datab,
  output logic [7:0] product
);

  assign product = {4'b0000, dataa} * {4'b0000, datab};

endmodule

module mult8x8_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product,
  output logic        done,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  ra_q, ra_d;
  logic [7:0]  rb_q, rb_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] product_q, product_d;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [7:0]  pp;
  logic [15:0] partial;
  logic [15:0] shifted;
  logic [15:0] sum;

  // P1 and P3 use the high nibble of ra; P2 and P3 use the high nibble of rb.
  assign a_nib = ((state_q == S_P1) || (state_q == S_P3)) ? ra_q[7:4] : ra_q[3:0];
  assign b_nib = ((state_q == S_P2) || (state_q == S_P3)) ? rb_q[7:4] : rb_q[3:0];

  mult4x4 u_mult4x4 (
    .dataa   (a_nib),
    .datab   (b_nib),
    .product (pp)
  );

  assign partial = {8'h00, pp};

  always_comb begin
    shifted = 16'h0000;
    case (state_q)
      S_P0:       shifted = partial;
      S_P1, S_P2: shifted = partial << 4;
      S_P3:       shifted = partial << 8;
      default:    shifted = 16'h0000;
    endcase
  end

  // Cannot overflow: 0xFF * 0xFF = 0xFE01.
  assign sum = acc_q + shifted;

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = dataa;
          rb_d    = datab;
          acc_d   = 16'h0000;
          state_d = S_P0;
        end
      end
      S_P0: begin
        acc_d   = sum;
        state_d = S_P1;
      end
      S_P1: begin
        acc_d   = sum;
        state_d = S_P2;
      end
      S_P2: begin
        acc_d   = sum;
        state_d = S_P3;
      end
      S_P3: begin
        // The final partial goes straight into product so it never shows
        // an intermediate sum.
        product_d = sum;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ra_q      <= 8'h00;
      rb_q      <= 8'h00;
      acc_q     <= 16'h0000;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q >= S_P0) && (state_q <= S_DONE);

endmodule
